// File: rtl/fixed_point_divider.sv
// Multi-cycle restoring divider for signed/unsigned fixed-point operands, one quotient bit per clock.
// Define FIXED_POINT_DIVIDER_SAT_EN to clamp y on overflow instead of wrapping.
module fixed_point_divider #(
    parameter int C_WIDTH     = 32,
    parameter int FIXED_POINT = 8
) (
    input  logic               ctl_clk,
    input  logic               reset,
    input  logic [C_WIDTH-1:0] a,
    input  logic [C_WIDTH-1:0] b,
    input  logic               signed_cal,
    input  logic               trigger,
    output logic [C_WIDTH-1:0] y,
    output logic               ready,
    output logic               done,
    output logic               div_zero,
    output logic               overflow
);

    localparam int N     = C_WIDTH + FIXED_POINT;
    localparam int CNT_W = $clog2(N);

    typedef enum logic [1:0] {IDLE, CALC, FINISH, DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [N-1:0]       dvd;
    logic [N-1:0]       quo;
    logic [C_WIDTH:0]   rem;
    logic [C_WIDTH-1:0] mag_b;
    logic               sgn;
    logic               neg;
    logic [CNT_W-1:0]   cnt;

    logic [C_WIDTH+1:0] rem_sh;
    logic [C_WIDTH+1:0] diff;
    logic               qbit;
    logic               ovf;

    function automatic logic [C_WIDTH-1:0] magnitude(input logic [C_WIDTH-1:0] v, input logic s);
        return (s && v[C_WIDTH-1]) ? (~v + C_WIDTH'(1)) : v;
    endfunction

    function automatic logic [N-1:0] mag_limit(input logic s, input logic n);
        logic [N-1:0] lim;
        if (!s)
            lim = {{FIXED_POINT{1'b0}}, {C_WIDTH{1'b1}}};
        else if (n)
            lim = {{FIXED_POINT{1'b0}}, 1'b1, {(C_WIDTH-1){1'b0}}};
        else
            lim = {{(FIXED_POINT+1){1'b0}}, {(C_WIDTH-1){1'b1}}};
        return lim;
    endfunction

    // Clamp value for the result sign; also the divide-by-zero answer.
    function automatic logic [C_WIDTH-1:0] sat_value(input logic s, input logic n);
        logic [C_WIDTH-1:0] v;
        if (!s)
            v = {C_WIDTH{1'b1}};
        else if (n)
            v = {1'b1, {(C_WIDTH-1){1'b0}}};
        else
            v = {1'b0, {(C_WIDTH-1){1'b1}}};
        return v;
    endfunction

    function automatic logic [C_WIDTH-1:0] wrap_value(input logic [N-1:0] q, input logic n);
        return n ? (~q[C_WIDTH-1:0] + C_WIDTH'(1)) : q[C_WIDTH-1:0];
    endfunction

    // rem[C_WIDTH] is always zero between steps, so the top bit of diff acts as the borrow.
    always_comb begin
        rem_sh = {rem, dvd[N-1]};
        diff   = rem_sh - {2'b00, mag_b};
        qbit   = ~diff[C_WIDTH+1];
        ovf    = quo > mag_limit(sgn, neg);
    end

    always_ff @(posedge ctl_clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (trigger)
                    state_nxt = (b == '0) ? FINISH : CALC;
            end
            CALC: begin
                if (cnt == CNT_W'(N-1))
                    state_nxt = FINISH;
            end
            FINISH: state_nxt = DONE;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ctl_clk or negedge reset) begin
        if (!reset) begin
            dvd      <= '0;
            quo      <= '0;
            rem      <= '0;
            mag_b    <= '0;
            sgn      <= 1'b0;
            neg      <= 1'b0;
            cnt      <= '0;
            y        <= '0;
            div_zero <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (trigger) begin
                        sgn      <= signed_cal;
                        neg      <= (a[C_WIDTH-1] ^ b[C_WIDTH-1]) & signed_cal;
                        dvd      <= {magnitude(a, signed_cal), {FIXED_POINT{1'b0}}};
                        mag_b    <= magnitude(b, signed_cal);
                        rem      <= '0;
                        quo      <= '0;
                        cnt      <= '0;
                        div_zero <= (b == '0);
                        overflow <= 1'b0;
                    end
                end
                CALC: begin
                    rem <= qbit ? diff[C_WIDTH:0] : rem_sh[C_WIDTH:0];
                    quo <= {quo[N-2:0], qbit};
                    dvd <= {dvd[N-2:0], 1'b0};
                    cnt <= cnt + 1'b1;
                end
                FINISH: begin
                    if (div_zero) begin
                        y <= sat_value(sgn, neg);
                    end else begin
                        overflow <= ovf;
`ifdef FIXED_POINT_DIVIDER_SAT_EN
                        y <= ovf ? sat_value(sgn, neg) : wrap_value(quo, neg);
`else
                        y <= wrap_value(quo, neg);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_point_divider.sv
// Directed bench for fixed_point_divider at C_WIDTH=16, FIXED_POINT=8 (24 quotient bits).
module tb_fixed_point_divider;

    localparam int CW = 16;
    localparam int FP = 8;
    localparam int N  = CW + FP;

`ifdef FIXED_POINT_DIVIDER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic          ctl_clk = 1'b0;
    logic          reset = 1'b0;
    logic [CW-1:0] a = '0;
    logic [CW-1:0] b = '0;
    logic          signed_cal = 1'b0;
    logic          trigger = 1'b0;
    logic [CW-1:0] y;
    logic          ready;
    logic          done;
    logic          div_zero;
    logic          overflow;

    always #5 ctl_clk = ~ctl_clk;

    fixed_point_divider #(.C_WIDTH(CW), .FIXED_POINT(FP)) dut (
        .ctl_clk    (ctl_clk),
        .reset      (reset),
        .a          (a),
        .b          (b),
        .signed_cal (signed_cal),
        .trigger    (trigger),
        .y          (y),
        .ready      (ready),
        .done       (done),
        .div_zero   (div_zero),
        .overflow   (overflow)
    );

    typedef struct {
        logic [CW-1:0] a;
        logic [CW-1:0] b;
        logic          s;
        logic [CW-1:0] y_wrap;
        logic [CW-1:0] y_sat;
        logic          dz;
        logic          ov;
    } vec_t;

    vec_t vecs[14];
    int   n_checks = 0;
    int   n_fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Starts one operation; optionally pulses trigger with junk operands after CALC edge pulse_at.
    task automatic run_op(input string tag, input logic [CW-1:0] ia, input logic [CW-1:0] ib,
                          input logic is, input int pulse_at,
                          output logic [CW-1:0] ry, output logic rdz, output logic rov, output int lat);
        @(negedge ctl_clk);
        a = ia; b = ib; signed_cal = is; trigger = 1'b1;
        @(posedge ctl_clk);
        @(negedge ctl_clk);
        trigger = 1'b0;
        a = ~ia; b = ~ib; signed_cal = ~is;
        lat = -1;
        for (int e = 1; e <= 60; e++) begin
            @(posedge ctl_clk);
            @(negedge ctl_clk);
            trigger = 1'b0;
            if (done) begin
                lat = e;
                break;
            end
            if (e == pulse_at) begin
                trigger = 1'b1; a = 16'hFFFF; b = 16'h0000;
            end
        end
        ry = y; rdz = div_zero; rov = overflow;
        check({tag, "_ready_in_done"}, 32'(ready), 32'd0);
        @(posedge ctl_clk);
        @(negedge ctl_clk);
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        check({tag, "_ready_back"}, 32'(ready), 32'd1);
    endtask

    initial begin
        logic [CW-1:0] ry;
        logic          rdz;
        logic          rov;
        int            lat;

        vecs[0]  = '{16'h0300, 16'h0200, 1'b0, 16'h0180, 16'h0180, 1'b0, 1'b0};
        vecs[1]  = '{16'hFD00, 16'h0200, 1'b1, 16'hFE80, 16'hFE80, 1'b0, 1'b0};
        vecs[2]  = '{16'h0100, 16'h0000, 1'b1, 16'h7FFF, 16'h7FFF, 1'b1, 1'b0};
        vecs[3]  = '{16'hFF00, 16'h0000, 1'b1, 16'h8000, 16'h8000, 1'b1, 1'b0};
        vecs[4]  = '{16'h7F00, 16'h0001, 1'b1, 16'h0000, 16'h7FFF, 1'b0, 1'b1};
        vecs[5]  = '{16'h0000, 16'h0300, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[6]  = '{16'h0100, 16'h0300, 1'b0, 16'h0055, 16'h0055, 1'b0, 1'b0};
        vecs[7]  = '{16'hFF00, 16'h0300, 1'b1, 16'hFFAB, 16'hFFAB, 1'b0, 1'b0};
        vecs[8]  = '{16'hFFFF, 16'h0100, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0};
        vecs[9]  = '{16'h8000, 16'h0100, 1'b1, 16'h8000, 16'h8000, 1'b0, 1'b0};
        vecs[10] = '{16'h8000, 16'hFF00, 1'b1, 16'h8000, 16'h7FFF, 1'b0, 1'b1};
        vecs[11] = '{16'h1234, 16'h0000, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0};
        vecs[12] = '{16'h8000, 16'h0200, 1'b0, 16'h4000, 16'h4000, 1'b0, 1'b0};
        vecs[13] = '{16'h0100, 16'h0001, 1'b0, 16'h0000, 16'hFFFF, 1'b0, 1'b1};

        #2;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_div_zero", 32'(div_zero), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        @(negedge ctl_clk);
        reset = 1'b1;

        for (int i = 0; i < 14; i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            run_op(tag, vecs[i].a, vecs[i].b, vecs[i].s, 0, ry, rdz, rov, lat);
            check({tag, "_y"}, 32'(ry), 32'(SAT ? vecs[i].y_sat : vecs[i].y_wrap));
            check({tag, "_div_zero"}, 32'(rdz), 32'(vecs[i].dz));
            check({tag, "_overflow"}, 32'(rov), 32'(vecs[i].ov));
            check({tag, "_latency"}, 32'(lat), vecs[i].dz ? 32'd1 : 32'(N + 1));
        end

        // Trigger pulsed mid-CALC with a divide-by-zero request must be dropped.
        run_op("ign", 16'h0300, 16'h0200, 1'b0, 5, ry, rdz, rov, lat);
        check("ign_y", 32'(ry), 32'h0180);
        check("ign_div_zero", 32'(rdz), 32'd0);
        check("ign_latency", 32'(lat), 32'(N + 1));
        run_op("after_ign", 16'hFD00, 16'h0200, 1'b1, 0, ry, rdz, rov, lat);
        check("after_ign_y", 32'(ry), 32'hFE80);
        check("after_ign_latency", 32'(lat), 32'(N + 1));

        // Asynchronous reset in the middle of CALC.
        @(negedge ctl_clk);
        a = 16'h0300; b = 16'h0200; signed_cal = 1'b0; trigger = 1'b1;
        @(posedge ctl_clk);
        @(negedge ctl_clk);
        trigger = 1'b0;
        repeat (9) @(posedge ctl_clk);
        @(negedge ctl_clk);
        check("mid_busy_ready", 32'(ready), 32'd0);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_ready", 32'(ready), 32'd1);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_y", 32'(y), 32'd0);
        @(negedge ctl_clk);
        reset = 1'b1;
        run_op("post_rst", 16'h0400, 16'h0200, 1'b0, 0, ry, rdz, rov, lat);
        check("post_rst_y", 32'(ry), 32'h0200);
        check("post_rst_flags", {30'd0, rdz, rov}, 32'd0);
        check("post_rst_latency", 32'(lat), 32'(N + 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
